// File: rtl/fifo_wptr_ctrl.sv
// Write-side pointer controller for a dual-clock FIFO. It keeps the binary and Gray
// write pointers, synchronizes the read Gray pointer, and derives full/level status.
module fifo_wptr_ctrl #(
   parameter int ABITS       = 4,
   parameter int SYNC_STAGES = 2,
   parameter int AFULL_LEVEL = 12
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             write_i,
   input  logic [ABITS:0]   rptr_gray_i,
   output logic [ABITS:0]   wptr_gray_o,
   output logic [ABITS-1:0] addr_o,
   output logic             wr_en_o,
   output logic             full_o,
   output logic             almost_full_o,
   output logic [ABITS:0]   level_o,
   output logic             overflow_o
);

   localparam int P = ABITS + 1;
   // Full means the pointers differ only in their top two Gray bits, so one XOR mask covers ABITS=1 too
   localparam logic [P-1:0] FULL_MASK = P'(3) << (P - 2);
   localparam logic [P-1:0] AFULL_THR = P'(AFULL_LEVEL);

   logic [P-1:0] syncQ [SYNC_STAGES];
   logic [P-1:0] wptrBinQ, wptrGrayQ, levelQ;
   logic         fullQ, almostFullQ, overflowQ;

   logic [P-1:0] rs, rbin, binNx, grayNx, levelNx;
   logic         wrEn, fullNx;

   assign rs = syncQ[SYNC_STAGES-1];

   // Raw capture of the read pointer is safe because successive Gray values differ in one bit
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            syncQ[i] <= '0;
         end
      end else begin
         syncQ[0] <= rptr_gray_i;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            syncQ[i] <= syncQ[i-1];
         end
      end
   end

   always_comb begin
      rbin = '0;
      for (int i = 0; i < P; i++) begin
         rbin[i] = ^(rs >> i);
      end
   end

   assign wrEn    = write_i & ~fullQ;
   assign binNx   = wptrBinQ + P'(wrEn);
   assign grayNx  = binNx ^ (binNx >> 1);
   assign fullNx  = (grayNx == (rs ^ FULL_MASK));
   assign levelNx = binNx - rbin;

   always_ff @(posedge clock) begin
      if (reset) begin
         wptrBinQ    <= '0;
         wptrGrayQ   <= '0;
         fullQ       <= 1'b0;
         almostFullQ <= 1'b0;
         levelQ      <= '0;
         overflowQ   <= 1'b0;
      end else begin
         wptrBinQ    <= binNx;
         wptrGrayQ   <= grayNx;
         fullQ       <= fullNx;
         almostFullQ <= (levelNx >= AFULL_THR);
         levelQ      <= levelNx;
         overflowQ   <= write_i & fullQ;
      end
   end

   assign wptr_gray_o   = wptrGrayQ;
   assign addr_o        = wptrBinQ[ABITS-1:0];
   assign wr_en_o       = wrEn;
   assign full_o        = fullQ;
   assign almost_full_o = almostFullQ;
   assign level_o       = levelQ;
   assign overflow_o    = overflowQ;

endmodule

// File: tb/tb_fifo_wptr_ctrl.sv
// Self-checking bench for fifo_wptr_ctrl: a count-based model pushes expected outputs
// into a queue as stimulus is driven, and each scenario pops and compares after the edge.
module tb_fifo_wptr_ctrl;

   localparam int ABITS = 4;
   localparam int P     = ABITS + 1;

   logic             clock = 1'b0;
   logic             reset = 1'b1;
   logic             write_i = 1'b0;
   logic [P-1:0]     rptr_gray_i = '0;
   logic [P-1:0]     wptr_gray_o;
   logic [ABITS-1:0] addr_o;
   logic             wr_en_o;
   logic             full_o;
   logic             almost_full_o;
   logic [P-1:0]     level_o;
   logic             overflow_o;

   fifo_wptr_ctrl #(.ABITS(ABITS), .SYNC_STAGES(2), .AFULL_LEVEL(12)) dut (
      .clock(clock), .reset(reset), .write_i(write_i), .rptr_gray_i(rptr_gray_i),
      .wptr_gray_o(wptr_gray_o), .addr_o(addr_o), .wr_en_o(wr_en_o), .full_o(full_o),
      .almost_full_o(almost_full_o), .level_o(level_o), .overflow_o(overflow_o)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [4:0] gray;
      logic [3:0] addr;
      logic       full;
      logic       afull;
      logic [4:0] level;
      logic       ovf;
   } outs_t;

   outs_t expQ[$];
   int    nChecks = 0;
   int    nFails  = 0;

   // Model state: write count, the two synchronizer copies of the read pointer, last full
   int         mBin = 0;
   logic [4:0] mSync0 = '0, mSync1 = '0;
   logic       mFull = 1'b0;
   int         wTot = 0;
   int         rTot = 0;

   function automatic logic [4:0] toGray(input int b);
      logic [4:0] v;
      v = b[4:0];
      return v ^ (v >> 1);
   endfunction

   function automatic int fromGray(input logic [4:0] g);
      int b = 0;
      for (int i = 4; i >= 0; i--) begin
         b = (b << 1) | ((b & 1) ^ int'(g[i]));
      end
      return b;
   endfunction

   function automatic outs_t observed();
      return {wptr_gray_o, addr_o, full_o, almost_full_o, level_o, overflow_o};
   endfunction

   task automatic applyStimulus(input logic rst, input logic wr, input logic [4:0] rg);
      outs_t e;
      int    binNx, lvl;
      @(negedge clock);
      reset       = rst;
      write_i     = wr;
      rptr_gray_i = rg;
      e = '0;
      if (rst) begin
         mBin = 0; mSync0 = '0; mSync1 = '0; mFull = 1'b0;
      end else begin
         binNx   = (mBin + ((wr && !mFull) ? 1 : 0)) % 32;
         lvl     = (binNx - fromGray(mSync1) + 32) % 32;
         e.gray  = toGray(binNx);
         e.addr  = binNx[3:0];
         e.full  = (lvl == 16);
         e.afull = (lvl >= 12);
         e.level = lvl[4:0];
         e.ovf   = wr & mFull;
         mBin    = binNx;
         mSync1  = mSync0;
         mSync0  = rg;
         mFull   = e.full;
      end
      expQ.push_back(e);
   endtask

   task automatic advance();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      outs_t e;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(i < 2, 1'b0, 5'd0);
         advance();
         e = expQ.pop_front();
         nChecks++;
         if (observed() !== e) begin
            nFails++;
            $display("[TB] FAIL reset[%0d]: got %h expected %h", i, observed(), e);
         end
      end
      nChecks++;
      if ({wptr_gray_o, addr_o, level_o, full_o, almost_full_o, overflow_o} !== 17'd0) begin
         nFails++;
         $display("[TB] FAIL reset_zero: got %h expected 0",
                  {wptr_gray_o, addr_o, level_o, full_o, almost_full_o, overflow_o});
      end
   endtask

   task automatic test_fill();
      outs_t e;
      for (int i = 0; i < 16; i++) begin
         if (!mFull) wTot++;
         applyStimulus(1'b0, 1'b1, 5'd0);
         advance();
         e = expQ.pop_front();
         nChecks++;
         if (observed() !== e) begin
            nFails++;
            $display("[TB] FAIL fill[%0d]: got %h expected %h", i, observed(), e);
         end
         nChecks++;
         if (level_o !== 5'(i + 1) || almost_full_o !== (i + 1 >= 12)) begin
            nFails++;
            $display("[TB] FAIL fill_level[%0d]: got level %0d afull %b expected level %0d afull %b",
                     i, level_o, almost_full_o, i + 1, (i + 1 >= 12));
         end
      end
      nChecks++;
      if (full_o !== 1'b1 || wptr_gray_o !== 5'b11000 || addr_o !== 4'd0) begin
         nFails++;
         $display("[TB] FAIL fill_end: got full %b gray %b addr %0d expected full 1 gray 11000 addr 0",
                  full_o, wptr_gray_o, addr_o);
      end
   endtask

   task automatic test_overflow();
      outs_t e;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, i < 2, 5'd0);
         #1;
         nChecks++;
         if (wr_en_o !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL ovf_wr_en[%0d]: got %b expected 0", i, wr_en_o);
         end
         advance();
         e = expQ.pop_front();
         nChecks++;
         if (observed() !== e || overflow_o !== (i < 2) || wptr_gray_o !== 5'b11000) begin
            nFails++;
            $display("[TB] FAIL overflow[%0d]: got %h (ovf %b) expected %h (ovf %b)",
                     i, observed(), overflow_o, e, (i < 2));
         end
      end
   endtask

   task automatic test_read_release();
      outs_t e;
      logic [4:0] rg;
      for (int step = 0; step < 2; step++) begin
         rg = (step == 0) ? 5'b00110 : 5'b00111;
         rTot = (step == 0) ? 4 : 5;
         for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, rg);
            advance();
            e = expQ.pop_front();
            nChecks++;
            if (observed() !== e) begin
               nFails++;
               $display("[TB] FAIL release%0d[%0d]: got %h expected %h", step, i, observed(), e);
            end
         end
         nChecks++;
         if (step == 0 && (full_o !== 1'b0 || level_o !== 5'd12 || almost_full_o !== 1'b1)) begin
            nFails++;
            $display("[TB] FAIL release_read4: got full %b level %0d afull %b expected 0 12 1",
                     full_o, level_o, almost_full_o);
         end else if (step == 1 && (level_o !== 5'd11 || almost_full_o !== 1'b0)) begin
            nFails++;
            $display("[TB] FAIL release_read5: got level %0d afull %b expected 11 0",
                     level_o, almost_full_o);
         end
      end
   endtask

   task automatic test_wrap();
      outs_t      e;
      logic [4:0] prev;
      logic       wr, sawWrap;
      sawWrap = 1'b0;
      prev    = wptr_gray_o;
      for (int it = 0; it < 400 && rTot < 45; it++) begin
         wr = ($urandom_range(0, 3) != 0);
         if (rTot < wTot && $urandom_range(0, 1) == 1) rTot++;
         if (wr && !mFull) wTot++;
         applyStimulus(1'b0, wr, toGray(rTot));
         advance();
         e = expQ.pop_front();
         nChecks++;
         if (observed() !== e) begin
            nFails++;
            $display("[TB] FAIL wrap[%0d]: got %h expected %h", it, observed(), e);
         end
         nChecks++;
         if ($countones(prev ^ wptr_gray_o) > 1 || level_o > 5'd16) begin
            nFails++;
            $display("[TB] FAIL wrap_gray[%0d]: got %b after %b level %0d expected one-bit step level<=16",
                     it, wptr_gray_o, prev, level_o);
         end
         if (prev == 5'b10000 && wptr_gray_o == 5'b00000) sawWrap = 1'b1;
         prev = wptr_gray_o;
      end
      nChecks++;
      if (rTot < 45 || sawWrap !== 1'b1) begin
         nFails++;
         $display("[TB] FAIL wrap_seen: got reads %0d wrap %b expected reads 45 wrap 1", rTot, sawWrap);
      end
   endtask

   task automatic test_reset_full();
      outs_t e;
      for (int i = 0; i < 40 && !mFull; i++) begin
         applyStimulus(1'b0, 1'b1, toGray(rTot));
         advance();
         e = expQ.pop_front();
         nChecks++;
         if (observed() !== e) begin
            nFails++;
            $display("[TB] FAIL refill[%0d]: got %h expected %h", i, observed(), e);
         end
      end
      nChecks++;
      if (full_o !== 1'b1) begin
         nFails++;
         $display("[TB] FAIL refill_full: got %b expected 1", full_o);
      end
      applyStimulus(1'b1, 1'b1, 5'd0);
      advance();
      e = expQ.pop_front();
      nChecks++;
      if (observed() !== e || observed() !== 17'd0) begin
         nFails++;
         $display("[TB] FAIL reset_while_full: got %h expected 0", observed());
      end
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, 1'b0, 5'd0);
         advance();
         e = expQ.pop_front();
         nChecks++;
         if (observed() !== e || level_o !== 5'd0) begin
            nFails++;
            $display("[TB] FAIL stale_rptr[%0d]: got %h level %0d expected %h level 0",
                     i, observed(), level_o, e);
         end
      end
   endtask

   initial begin
      $display("[TB] starting fifo_wptr_ctrl bench");
      test_reset();
      test_fill();
      test_overflow();
      test_read_release();
      test_wrap();
      test_reset_full();
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

   // Guards against a stalled run so the bench always terminates
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/fifo_wptr_ctrl.md
Name: fifo_wptr_ctrl

Overview:
Write-side pointer controller for the dual-clock FIFOs in the counter library. It lives entirely in the write clock domain. It sequences the binary write pointer and its Gray-coded copy, and brings the read side's Gray pointer into the write domain through a synchronizer. From these it produces full, almost-full, fill level and overflow status. A matching read-side controller and a dual-port RAM complete the FIFO.

Parameters:
ABITS, 4, RAM address width; FIFO depth = 2**ABITS; pointers are ABITS+1 bits wide (P = ABITS+1); ABITS >= 1.
SYNC_STAGES, 2, flip-flops in the rptr_gray_i synchronizer; must be >= 2.
AFULL_LEVEL, 12, almost_full_o asserts when level >= AFULL_LEVEL; range 1..2**ABITS.

Ports:
clock  in  1  write-domain clock; all logic is on its rising edge.
reset  in  1  synchronous, active-high reset.
write_i  in  1  write request for the current cycle.
rptr_gray_i  in  P  Gray read pointer from the read clock domain; asynchronous to clock.
wptr_gray_o  out  P  registered Gray write pointer, sent to the read domain.
addr_o  out  ABITS  RAM write address = wptr_bin[ABITS-1:0].
wr_en_o  out  1  combinational: write_i & ~full_o; the RAM write strobe.
full_o  out  1  registered full flag.
almost_full_o  out  1  registered almost-full flag.
level_o  out  P  registered fill level, 0..2**ABITS.
overflow_o  out  1  registered one-cycle pulse when a write is rejected.

Behaviour:
- Reset: reset is synchronous, active-high; clock is clock. On reset the following are cleared to 0:
  - wptr_bin and wptr_gray_o;
  - all synchronizer stages;
  - full_o, almost_full_o, level_o and overflow_o.
  Reset takes priority over write_i at any time, including while full_o=1.
- Synchronizer: rptr_gray_i passes through SYNC_STAGES flip-flops; rs denotes the last stage. No logic sits between stages. The input is captured raw, because the Gray code guarantees a single-bit change per step.
- Accept rule: wr_en = write_i & ~full_o. write_i while full_o=1 is ignored: the pointer holds and overflow_o pulses high on the next cycle.
- Next-state values:
  - bin_nx = wptr_bin + wr_en, modulo 2**P;
  - gray_nx = bin_nx ^ (bin_nx >> 1).
  - Registered each cycle: wptr_bin <= bin_nx; wptr_gray_o <= gray_nx.
- Full is computed from the next pointer:
  - full_o <= (gray_nx == {~rs[P-1:P-2], rs[P-3:0]});
  - for ABITS=1, both bits of rs are inverted.
- Level is also computed from the next pointer:
  - rbin = Gray-to-binary of rs (prefix XOR from the MSB);
  - level_o <= (bin_nx - rbin) mod 2**P;
  - almost_full_o <= (that same level >= AFULL_LEVEL).
- Latency:
  - An accepted write is reflected in wptr_gray_o, level_o and full_o one cycle later.
  - A change on rptr_gray_i is reflected in level_o, full_o and almost_full_o SYNC_STAGES+1 cycles later.
- Simultaneous events: an accepted write and a synchronized read-pointer change in the same cycle are both applied in that cycle's update, so the level nets out.
- Wrap: the pointers wrap from 2**P-1 to 0 (Gray 1000..0 to 0000..0). full and level remain correct across the wrap.
- wptr_gray_o changes at most one bit per cycle and is glitch-free (registered, no combinational path out).
- Full is conservative: because of synchronizer lag, full_o may stay high after a read but never deasserts early. level_o never exceeds 2**ABITS.

Test Plan:
(All scenarios use ABITS=4, SYNC_STAGES=2, AFULL_LEVEL=12.)
1. Reset held 2 cycles, then released -> wptr_gray_o=0, addr_o=0, level_o=0, full_o=0, almost_full_o=0, overflow_o=0.
2. rptr_gray_i=0; write_i high for 16 cycles -> level_o counts 1..16; almost_full_o rises with level_o=12; after the 16th write full_o=1, wptr_gray_o=5'b11000, addr_o=0.
3. Continue write_i for 2 more cycles while full -> wptr_gray_o holds 5'b11000; wr_en_o=0; overflow_o high for 2 cycles, then low.
4. From full, set rptr_gray_i=5'b00110 (binary 4) -> full_o falls exactly 3 cycles later; level_o=12; almost_full_o stays 1. Next, rptr_gray_i=5'b00111 (binary 5) -> level_o=11 and almost_full_o=0, 3 cycles later.
5. Interleave writes with rptr_gray_i stepping through the Gray sequence for 40 increments -> wptr_gray_o wraps from 5'b10000 to 5'b00000; every transition is single-bit; level_o always equals writes minus (reads delayed 2 cycles), with no false full.
6. Assert reset while full_o=1 and write_i=1 -> next cycle all outputs 0; a stale rptr value does not reappear after reset deasserts.
